// File: rtl/seq_ctrl_if.sv
// Phase/opcode/flag inputs and control strobes between the phase generator side
// and the RISC-Y sequence controller.
interface seq_ctrl_if;
  logic [1:0] phase;
  logic [3:0] opcode;
  logic       zero;
  logic       carry;
  logic       ir_ld;
  logic       pc_inc;
  logic       pc_ld;
  logic       mem_rd;
  logic       mem_wr;
  logic       acc_ld;
  logic       mar_sel;
  logic [2:0] alu_op;
  logic       halt;
  logic       seq_err;
  logic       ill_op;

  modport master (
    output phase, opcode, zero, carry,
    input  ir_ld, pc_inc, pc_ld, mem_rd, mem_wr, acc_ld,
    input  mar_sel, alu_op, halt, seq_err, ill_op
  );

  modport slave (
    input  phase, opcode, zero, carry,
    output ir_ld, pc_inc, pc_ld, mem_rd, mem_wr, acc_ld,
    output mar_sel, alu_op, halt, seq_err, ill_op
  );
endinterface

// File: rtl/seq_ctrl.sv
// RISC-Y sequence controller: turns each legal phase entry into one-cycle control
// strobes, tracks phase-sequence legality and handles HALT / reserved opcodes.
module seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  seq_ctrl_if.slave   bus
);

  localparam logic [1:0] PH_FETCH   = 2'd0;
  localparam logic [1:0] PH_DECODE  = 2'd1;
  localparam logic [1:0] PH_EXECUTE = 2'd2;
  localparam logic [1:0] PH_UPDATE  = 2'd3;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_NOT  = 3'd5;
  localparam logic [2:0] ALU_PASS = 3'd6;

  // FRESH syncs on any FETCH sample; LOST needs an actual change into FETCH so a
  // FETCH that was itself the illegal entry does not get replayed.
  typedef enum logic [1:0] {
    SYNC_FRESH,
    SYNC_LOST,
    SYNC_OK
  } sync_t;

  sync_t      sync_state, sync_next;
  logic [1:0] prev_phase;
  logic [1:0] expected_phase;
  logic       entry;
  logic       illegal;

  logic       ir_ld_q, pc_inc_q, pc_ld_q, mem_rd_q, mem_wr_q, acc_ld_q;
  logic       ir_ld_d, pc_inc_d, pc_ld_d, mem_rd_d, mem_wr_d, acc_ld_d;
  logic       mar_sel_q, mar_sel_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic       halt_q, halt_d;
  logic       seq_err_q, seq_err_d;
  logic       ill_op_q, ill_op_d;
  logic [3:0] op_q, op_d;
  logic       take_q, take_d;
  logic       fire;

  function automatic logic reads_mem(input logic [3:0] op);
    return (op == OP_LDA) || ((op >= OP_ADD) && (op <= OP_XOR));
  endfunction

  function automatic logic loads_acc(input logic [3:0] op);
    return (op == OP_LDA) || ((op >= OP_ADD) && (op <= OP_NOT));
  endfunction

  function automatic logic uses_operand(input logic [3:0] op);
    return ((op >= OP_LDA) && (op <= OP_XOR)) || ((op >= OP_JMP) && (op <= OP_JC));
  endfunction

  function automatic logic is_jump(input logic [3:0] op);
    return (op >= OP_JMP) && (op <= OP_JC);
  endfunction

  function automatic logic is_reserved(input logic [3:0] op);
    return (op >= 4'hC) && (op <= 4'hE);
  endfunction

  function automatic logic [2:0] alu_map(input logic [3:0] op, input logic [2:0] cur);
    logic [2:0] code;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      OP_XOR:  code = ALU_XOR;
      OP_NOT:  code = ALU_NOT;
      OP_LDA:  code = ALU_PASS;
      default: code = cur;
    endcase
    return code;
  endfunction

  assign expected_phase = prev_phase + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_state <= SYNC_FRESH;
      prev_phase <= PH_FETCH;
    end else begin
      sync_state <= sync_next;
      prev_phase <= bus.phase;
    end
  end

  always_comb begin
    sync_next = sync_state;
    entry     = 1'b0;
    illegal   = 1'b0;
    case (sync_state)
      SYNC_FRESH: begin
        if (bus.phase == PH_FETCH) begin
          sync_next = SYNC_OK;
          entry     = 1'b1;
        end
      end
      SYNC_LOST: begin
        if ((bus.phase == PH_FETCH) && (bus.phase != prev_phase)) begin
          sync_next = SYNC_OK;
          entry     = 1'b1;
        end
      end
      SYNC_OK: begin
        if (bus.phase != prev_phase) begin
          if (bus.phase == expected_phase) begin
            entry = 1'b1;
          end else begin
            illegal   = 1'b1;
            sync_next = SYNC_LOST;
          end
        end
      end
      default: sync_next = SYNC_FRESH;
    endcase
  end

  assign fire = entry && !halt_q;

  // Everything the controller does for a phase entry; held levels default to
  // their current value and strobes default to idle.
  always_comb begin
    ir_ld_d   = 1'b0;
    pc_inc_d  = 1'b0;
    pc_ld_d   = 1'b0;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    acc_ld_d  = 1'b0;
    mar_sel_d = mar_sel_q;
    alu_op_d  = alu_op_q;
    op_d      = op_q;
    take_d    = take_q;
    halt_d    = halt_q;
    seq_err_d = seq_err_q | illegal;
    ill_op_d  = ill_op_q;
    if (fire) begin
      case (bus.phase)
        PH_FETCH: begin
          ir_ld_d   = 1'b1;
          mem_rd_d  = 1'b1;
          mar_sel_d = 1'b0;
        end
        PH_DECODE: begin
          pc_inc_d  = 1'b1;
          op_d      = bus.opcode;
          mar_sel_d = uses_operand(bus.opcode);
          alu_op_d  = alu_map(bus.opcode, alu_op_q);
        end
        PH_EXECUTE: begin
          mem_rd_d = reads_mem(op_q);
          mem_wr_d = (op_q == OP_STA);
          case (op_q)
            OP_JMP:  take_d = 1'b1;
            OP_JZ:   take_d = bus.zero;
            OP_JC:   take_d = bus.carry;
            default: take_d = take_q;
          endcase
        end
        PH_UPDATE: begin
          acc_ld_d = loads_acc(op_q);
          pc_ld_d  = is_jump(op_q) && take_q;
          if (op_q == OP_HLT) halt_d = 1'b1;
          if (is_reserved(op_q)) ill_op_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_ld_q   <= 1'b0;
      pc_inc_q  <= 1'b0;
      pc_ld_q   <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      acc_ld_q  <= 1'b0;
      mar_sel_q <= 1'b0;
      alu_op_q  <= ALU_ADD;
      halt_q    <= 1'b0;
      seq_err_q <= 1'b0;
      ill_op_q  <= 1'b0;
      op_q      <= 4'h0;
      take_q    <= 1'b0;
    end else begin
      ir_ld_q   <= ir_ld_d;
      pc_inc_q  <= pc_inc_d;
      pc_ld_q   <= pc_ld_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      acc_ld_q  <= acc_ld_d;
      mar_sel_q <= mar_sel_d;
      alu_op_q  <= alu_op_d;
      halt_q    <= halt_d;
      seq_err_q <= seq_err_d;
      ill_op_q  <= ill_op_d;
      op_q      <= op_d;
      take_q    <= take_d;
    end
  end

  assign bus.ir_ld   = ir_ld_q;
  assign bus.pc_inc  = pc_inc_q;
  assign bus.pc_ld   = pc_ld_q;
  assign bus.mem_rd  = mem_rd_q;
  assign bus.mem_wr  = mem_wr_q;
  assign bus.acc_ld  = acc_ld_q;
  assign bus.mar_sel = mar_sel_q;
  assign bus.alu_op  = alu_op_q;
  assign bus.halt    = halt_q;
  assign bus.seq_err = seq_err_q;
  assign bus.ill_op  = ill_op_q;

endmodule
